// File: rtl/control_minado.sv
// Nonce-search sequencer: sweeps a 32-bit nonce through the hash core and stops on
// the first hash below target, on nonce exhaustion, or on a core timeout.
module control_minado #(
    parameter logic [31:0] MAX_NONCE    = 32'hFFFF_FFFF,
    parameter logic [15:0] CORE_TIMEOUT = 16'd1024
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        inicio_i,
    input  logic [95:0] bloque_bytes_i,
    input  logic [7:0]  target_i,
    output logic        core_inicio_o,
    output logic [95:0] core_bloque_o,
    input  logic        core_listo_i,
    input  logic [23:0] core_hash_i,
    output logic        terminado_o,
    output logic        encontrado_o,
    output logic        error_timeout_o,
    output logic [31:0] nonce_out_o,
    output logic [23:0] hash_o,
    output logic [31:0] ciclos_o,
    output logic [31:0] intentos_o
);

    typedef enum logic [2:0] {IDLE, CARGA, LANZA, ESPERA, COMPARA, FIN} state_t;

    state_t      state_q;
    logic [63:0] base_q;
    logic [7:0]  target_q;
    logic [31:0] nonce_q, nonce_d;
    logic [15:0] to_q;
    logic        core_inicio_q;
    logic [95:0] core_bloque_q;
    logic        terminado_q, encontrado_q, error_to_q;
    logic [31:0] nonce_out_q;
    logic [23:0] hash_q;
    logic [31:0] ciclos_q, ciclos_d;
    logic [31:0] intentos_q, intentos_d;
    logic        hit_d;

    // The low 32 block bits are always overwritten by the nonce.
    logic unused_bits;
    assign unused_bits = ^bloque_bytes_i[31:0];

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        nonce_d    = nonce_q + 32'd1;
        ciclos_d   = sat_inc(ciclos_q);
        intentos_d = sat_inc(intentos_q);
        hit_d      = hash_q[23:16] < target_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            base_q        <= '0;
            target_q      <= '0;
            nonce_q       <= '0;
            to_q          <= '0;
            core_inicio_q <= 1'b0;
            core_bloque_q <= '0;
            terminado_q   <= 1'b0;
            encontrado_q  <= 1'b0;
            error_to_q    <= 1'b0;
            nonce_out_q   <= '0;
            hash_q        <= '0;
            ciclos_q      <= '0;
            intentos_q    <= '0;
        end else begin
            core_inicio_q <= 1'b0;
            if (state_q inside {CARGA, LANZA, ESPERA, COMPARA})
                ciclos_q <= ciclos_d;
            unique case (state_q)
                IDLE: begin
                    if (inicio_i) begin
                        base_q       <= bloque_bytes_i[95:32];
                        target_q     <= target_i;
                        nonce_q      <= '0;
                        ciclos_q     <= '0;
                        intentos_q   <= '0;
                        encontrado_q <= 1'b0;
                        error_to_q   <= 1'b0;
                        state_q      <= CARGA;
                    end
                end
                CARGA: begin
                    core_bloque_q <= {base_q, nonce_q};
                    core_inicio_q <= 1'b1;
                    state_q       <= LANZA;
                end
                LANZA: begin
                    to_q    <= '0;
                    state_q <= ESPERA;
                end
                ESPERA: begin
                    // A result in the same cycle as the timeout still counts.
                    if (core_listo_i) begin
                        hash_q      <= core_hash_i;
                        nonce_out_q <= nonce_q;
                        state_q     <= COMPARA;
                    end else if (CORE_TIMEOUT != 16'd0 && to_q == CORE_TIMEOUT - 16'd1) begin
                        error_to_q   <= 1'b1;
                        encontrado_q <= 1'b0;
                        terminado_q  <= 1'b1;
                        state_q      <= FIN;
                    end else begin
                        to_q <= to_q + 16'd1;
                    end
                end
                COMPARA: begin
                    intentos_q <= intentos_d;
                    if (hit_d) begin
                        encontrado_q <= 1'b1;
                        terminado_q  <= 1'b1;
                        state_q      <= FIN;
                    end else if (nonce_q == MAX_NONCE) begin
                        encontrado_q <= 1'b0;
                        terminado_q  <= 1'b1;
                        state_q      <= FIN;
                    end else begin
                        nonce_q       <= nonce_d;
                        core_bloque_q <= {base_q, nonce_d};
                        core_inicio_q <= 1'b1;
                        state_q       <= LANZA;
                    end
                end
                FIN: begin
                    // Wait for inicio to drop so a held request cannot restart the sweep.
                    if (!inicio_i) begin
                        terminado_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign core_inicio_o   = core_inicio_q;
    assign core_bloque_o   = core_bloque_q;
    assign terminado_o     = terminado_q;
    assign encontrado_o    = encontrado_q;
    assign error_timeout_o = error_to_q;
    assign nonce_out_o     = nonce_out_q;
    assign hash_o          = hash_q;
    assign ciclos_o        = ciclos_q;
    assign intentos_o      = intentos_q;

endmodule

// File: tb/tb_control_minado.sv
// Directed bench for control_minado: two instances (default range, and MAX_NONCE=15 /
// CORE_TIMEOUT=8) each driven by a fixed-latency core model.
module tb_control_minado;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: default parameters
    logic        rst_a = 1'b1, ini_a = 1'b0;
    logic [95:0] blq_a = '0;
    logic [7:0]  tgt_a = '0;
    logic        ci_a, cl_a = 1'b0;
    logic [95:0] cb_a;
    logic [23:0] ch_a = '0;
    logic        term_a, enc_a, eto_a;
    logic [31:0] nout_a, cic_a, int_a;
    logic [23:0] hsh_a;

    // Instance B: short range and short timeout
    logic        rst_b = 1'b1, ini_b = 1'b0;
    logic [95:0] blq_b = '0;
    logic [7:0]  tgt_b = '0;
    logic        ci_b, cl_b = 1'b0;
    logic [95:0] cb_b;
    logic [23:0] ch_b = '0;
    logic        term_b, enc_b, eto_b;
    logic [31:0] nout_b, cic_b, int_b;
    logic [23:0] hsh_b;

    control_minado u_a (
        .clk_i(clk), .reset_i(rst_a), .inicio_i(ini_a), .bloque_bytes_i(blq_a),
        .target_i(tgt_a), .core_inicio_o(ci_a), .core_bloque_o(cb_a),
        .core_listo_i(cl_a), .core_hash_i(ch_a), .terminado_o(term_a),
        .encontrado_o(enc_a), .error_timeout_o(eto_a), .nonce_out_o(nout_a),
        .hash_o(hsh_a), .ciclos_o(cic_a), .intentos_o(int_a)
    );

    control_minado #(.MAX_NONCE(32'd15), .CORE_TIMEOUT(16'd8)) u_b (
        .clk_i(clk), .reset_i(rst_b), .inicio_i(ini_b), .bloque_bytes_i(blq_b),
        .target_i(tgt_b), .core_inicio_o(ci_b), .core_bloque_o(cb_b),
        .core_listo_i(cl_b), .core_hash_i(ch_b), .terminado_o(term_b),
        .encontrado_o(enc_b), .error_timeout_o(eto_b), .nonce_out_o(nout_b),
        .hash_o(hsh_b), .ciclos_o(cic_b), .intentos_o(int_b)
    );

    // Core model A: listo on the 4th ESPERA cycle, optional stray pulses in LANZA/COMPARA
    int          cnt_a = 0;
    logic        post_a = 1'b0, stray_a = 1'b0, bad_hi = 1'b0;
    logic [63:0] exp_hi = 64'h61696370_21000003;
    always @(negedge clk) begin
        cl_a = 1'b0;
        if (post_a) begin
            post_a = 1'b0;
            if (stray_a) cl_a = 1'b1;
        end
        if (ci_a) begin
            cnt_a = 4;
            ch_a  = {8'hFF - cb_a[7:0], 16'h0};
            if (cb_a[95:32] != exp_hi) bad_hi = 1'b1;
            if (stray_a) cl_a = 1'b1;
        end else if (cnt_a != 0) begin
            cnt_a--;
            if (cnt_a == 0) begin
                cl_a   = 1'b1;
                post_a = 1'b1;
            end
        end
    end

    // Core model B: same latency, can be muted to force a timeout
    int   cnt_b = 0;
    logic mute_b = 1'b0;
    always @(negedge clk) begin
        cl_b = 1'b0;
        if (ci_b && !mute_b) begin
            cnt_b = 4;
            ch_b  = {8'hFF - cb_b[7:0], 16'h0};
        end else if (cnt_b != 0) begin
            cnt_b--;
            if (cnt_b == 0) cl_b = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic wait_term_a(input int lim, input string tag);
        int n = 0;
        while (term_a !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_terminado"}, term_a, 1);
    endtask

    task automatic wait_term_b(input int lim, input string tag);
        int n = 0;
        while (term_b !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_terminado"}, term_b, 1);
    endtask

    task automatic check_hit_a(input string tag);
        check({tag, "_enc"}, enc_a, 1);
        check({tag, "_eto"}, eto_a, 0);
        check({tag, "_nonce"}, nout_a, 32'hF0);
        check({tag, "_hash"}, hsh_a[23:16], 8'h0F);
        check({tag, "_intentos"}, int_a, 241);
        check({tag, "_ciclos"}, cic_a, 1447);
    endtask

    initial begin
        int p, lo, n;
        repeat (3) @(negedge clk);
        check("rst_outputs", {ci_a, term_a, enc_a, eto_a, nout_a, hsh_a}, 0);
        check("rst_counters", {cic_a, int_a}, 0);
        check("rst_bloque", cb_a, 0);
        rst_a = 1'b0;

        // 1. hit at nonce 0xF0, inicio held
        blq_a = 96'h61696370_21000003_170800F3;
        tgt_a = 8'h10;
        ini_a = 1'b1;
        wait_term_a(3000, "hit");
        check_hit_a("hit");
        check("hit_base_hi", bad_hi, 0);

        // 4. held start stays in FIN, then a drop/reassert restarts
        p = 0; lo = 0;
        repeat (50) begin
            @(negedge clk);
            if (ci_a) p++;
            if (!term_a) lo++;
        end
        check("held_pulses", p, 0);
        check("held_term_drop", lo, 0);
        ini_a = 1'b0;
        @(negedge clk);
        check("fin_exit_term", term_a, 0);
        check("fin_exit_hold_enc", enc_a, 1);
        ini_a = 1'b1;
        @(negedge clk);
        check("restart_clear", {int_a, cic_a, 31'd0, enc_a}, 0);
        @(negedge clk);
        check("restart_launch", {ci_a, cic_a}, {1'b1, 32'd1});

        // 5. reset during ESPERA of attempt 10
        n = 1;
        p = 0;
        while (n < 10 && p < 200) begin
            @(negedge clk);
            p++;
            if (ci_a) n++;
        end
        check("launch10_seen", n, 10);
        check("launch10_intentos", int_a, 9);
        @(negedge clk);
        rst_a = 1'b1;
        ini_a = 1'b0;
        @(negedge clk);
        check("midrst_flags", {ci_a, term_a, enc_a, eto_a}, 0);
        check("midrst_data", {nout_a, hsh_a}, 0);
        check("midrst_counters", {cic_a, int_a}, 0);
        check("midrst_bloque", cb_a, 0);
        rst_a = 1'b0;
        repeat (5) @(negedge clk);
        check("late_listo_ignored", {term_a, ci_a, int_a, nout_a, hsh_a}, 0);
        ini_a = 1'b1;
        @(negedge clk);
        // latched inputs must not follow these changes
        blq_a = '0;
        tgt_a = 8'hFF;
        ini_a = 1'b0;
        wait_term_a(3000, "rerun");
        check_hit_a("rerun");

        // 6. stray listo in LANZA and COMPARA
        @(negedge clk);
        blq_a   = 96'h61696370_21000003_170800F3;
        tgt_a   = 8'h10;
        stray_a = 1'b1;
        ini_a   = 1'b1;
        wait_term_a(3000, "stray");
        check_hit_a("stray");
        stray_a = 1'b0;

        // 2. exhaust on instance B
        rst_b = 1'b0;
        blq_b = 96'hDEADBEEF_01234567_89ABCDEF;
        tgt_b = 8'h00;
        ini_b = 1'b1;
        wait_term_b(500, "exh");
        check("exh_enc", enc_b, 0);
        check("exh_eto", eto_b, 0);
        check("exh_nonce", nout_b, 15);
        check("exh_hash", hsh_b, 24'hF0_0000);
        check("exh_intentos", int_b, 16);
        check("exh_ciclos", cic_b, 97);

        // 3. timeout: core never answers
        ini_b = 1'b0;
        @(negedge clk);
        mute_b = 1'b1;
        ini_b  = 1'b1;
        wait_term_b(100, "tmo");
        check("tmo_eto", eto_b, 1);
        check("tmo_enc", enc_b, 0);
        check("tmo_intentos", int_b, 0);
        check("tmo_ciclos", cic_b, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
